// File: rtl/control_pkg.sv
// control_pkg: shared state encoding and instruction class constants for the control sequencer.
package control_pkg;
  typedef enum logic [2:0] {FETCH, FETCH_IMM, EX1, EX2, LDI, HALT} state_e;
  localparam logic [1:0] CLS_SYS = 2'b00;
  localparam logic [1:0] CLS_MOV = 2'b01;
  localparam logic [1:0] CLS_ALU = 2'b10;
  localparam logic [1:0] CLS_LDI = 2'b11;
  localparam int ALU_PASS = 0;
endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: instruction handshake plus datapath strobe bundle.
// master drives instructions and observes strobes; slave is the sequencer.
interface control_sequencer_if #(
  parameter int FIELD_W = 3,
  parameter int DATA_W  = 8
);
  localparam int INST_W = 2 + 2 * FIELD_W;
  logic [INST_W-1:0]  inst;
  logic               instValid;
  logic               instReady;
  logic [FIELD_W-1:0] regSel;
  logic [FIELD_W-1:0] aluSel;
  logic               Rin;
  logic               Rout;
  logic               RAin;
  logic               RCout;
  logic               genConst;
  logic [DATA_W-1:0]  constVal;
  logic               halted;
  modport master (
    output inst, instValid,
    input  instReady, regSel, aluSel, Rin, Rout, RAin, RCout, genConst, constVal, halted
  );
  modport slave (
    input  inst, instValid,
    output instReady, regSel, aluSel, Rin, Rout, RAin, RCout, genConst, constVal, halted
  );
endinterface

// File: rtl/control_decode.sv
// control_decode: combinational map from state and held instruction/immediate to strobes.
module control_decode import control_pkg::*; #(
  parameter int FIELD_W = 3,
  parameter int DATA_W  = 8,
  parameter int ACC_REG = 0,
  localparam int INST_W = 2 + 2 * FIELD_W
) (
  input  state_e             state_i,
  input  logic [INST_W-1:0]  ir_i,
  input  logic [DATA_W-1:0]  imm_i,
  output logic [FIELD_W-1:0] reg_sel_o,
  output logic [FIELD_W-1:0] alu_sel_o,
  output logic               rin_o,
  output logic               rout_o,
  output logic               rain_o,
  output logic               rcout_o,
  output logic               gen_const_o,
  output logic [DATA_W-1:0]  const_val_o
);
  logic [1:0]         cls;
  logic [FIELD_W-1:0] fa;
  logic [FIELD_W-1:0] fb;
  logic               is_alu;
  assign cls    = ir_i[INST_W-1 -: 2];
  assign fa     = ir_i[2*FIELD_W-1 -: FIELD_W];
  assign fb     = ir_i[FIELD_W-1:0];
  assign is_alu = cls == CLS_ALU;
  always_comb begin
    reg_sel_o   = '0;
    alu_sel_o   = '0;
    rin_o       = 1'b0;
    rout_o      = 1'b0;
    rain_o      = 1'b0;
    rcout_o     = 1'b0;
    gen_const_o = 1'b0;
    const_val_o = '0;
    case (state_i)
      EX1: begin
        reg_sel_o = fb;
        rout_o    = 1'b1;
        rain_o    = 1'b1;
      end
      EX2: begin
        alu_sel_o = is_alu ? fa : FIELD_W'(ALU_PASS);
        reg_sel_o = is_alu ? FIELD_W'(ACC_REG) : fa;
        rcout_o   = 1'b1;
        rin_o     = 1'b1;
      end
      LDI: begin
        reg_sel_o   = fb;
        gen_const_o = 1'b1;
        rin_o       = 1'b1;
        const_val_o = imm_i;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: Moore sequencer stepping accepted instructions through fetch,
// immediate-fetch and execute phases; strobes come only from state and captured words.
module control_sequencer import control_pkg::*; #(
  parameter int FIELD_W = 3,
  parameter int DATA_W  = 8,
  parameter int ACC_REG = 0
) (
  input logic                clk,
  input logic                rst,
  control_sequencer_if.slave bus
);
  localparam int INST_W = 2 + 2 * FIELD_W;
  state_e              state_q, state_d;
  logic [INST_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic                take;
  logic [1:0]          cls_in;
  logic                halt_in;
  assign take    = bus.instValid & bus.instReady;
  assign cls_in  = bus.inst[INST_W-1 -: 2];
  assign halt_in = &bus.inst[FIELD_W-1:0];
  // Gating with rst keeps instReady low for the whole reset window.
  assign bus.instReady = rst & (state_q == FETCH || state_q == FETCH_IMM);
  assign bus.halted    = state_q == HALT;
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
    case (state_q)
      FETCH: if (take) begin
        ir_d = bus.inst;
        if (cls_in == CLS_SYS) state_d = halt_in ? HALT : FETCH;
        else if (cls_in == CLS_LDI) state_d = FETCH_IMM;
        else state_d = EX1;
      end
      FETCH_IMM: if (take) begin
        imm_d   = bus.inst[DATA_W-1:0];
        state_d = LDI;
      end
      EX1:     state_d = EX2;
      EX2:     state_d = FETCH;
      LDI:     state_d = FETCH;
      default: state_d = HALT;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      ir_q    <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
    end
  end
  control_decode #(.FIELD_W(FIELD_W), .DATA_W(DATA_W), .ACC_REG(ACC_REG)) u_decode (
    .state_i     (state_q),
    .ir_i        (ir_q),
    .imm_i       (imm_q),
    .reg_sel_o   (bus.regSel),
    .alu_sel_o   (bus.aluSel),
    .rin_o       (bus.Rin),
    .rout_o      (bus.Rout),
    .rain_o      (bus.RAin),
    .rcout_o     (bus.RCout),
    .gen_const_o (bus.genConst),
    .const_val_o (bus.constVal)
  );
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed vectors with hand-computed strobe patterns.
module tb_control_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;
  localparam logic [4:0] S_NONE = 5'b00000;
  localparam logic [4:0] S_RD   = 5'b01100;
  localparam logic [4:0] S_WR   = 5'b10010;
  localparam logic [4:0] S_LD   = 5'b10001;
  control_sequencer_if #(.FIELD_W(3), .DATA_W(8)) bus ();
  control_sequencer #(.FIELD_W(3), .DATA_W(8), .ACC_REG(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  always #5 clk = ~clk;
  logic [20:0] obs;
  assign obs = {bus.instReady, bus.halted, bus.regSel, bus.aluSel,
                bus.Rin, bus.Rout, bus.RAin, bus.RCout, bus.genConst, bus.constVal};
  function automatic logic [20:0] pk(input logic rdy, input logic hlt, input logic [2:0] rs,
                                     input logic [2:0] as, input logic [4:0] st, input logic [7:0] cv);
    return {rdy, hlt, rs, as, st, cv};
  endfunction
  task automatic check(input string tag, input logic [20:0] got, input logic [20:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic [7:0] i, input logic v);
    bus.inst      = i;
    bus.instValid = v;
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    rst = 1'b0;
    bus.inst = 8'hFF;
    bus.instValid = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_all0", obs, '0);
    bus.inst = 8'h00;
    rst = 1'b1;
    #1 check("rst_rel", obs, pk(1, 0, 0, 0, S_NONE, 0));
    @(negedge clk);
    step(8'h00, 1); check("nop0", obs, pk(1, 0, 0, 0, S_NONE, 0));
    step(8'h38, 1); check("nop38", obs, pk(1, 0, 0, 0, S_NONE, 0));
    step(8'h95, 1); check("alu_ex1", obs, pk(0, 0, 5, 0, S_RD, 0));
    step(8'h95, 0); check("alu_ex2", obs, pk(0, 0, 0, 2, S_WR, 0));
    step(8'h95, 0); check("alu_done", obs, pk(1, 0, 0, 0, S_NONE, 0));
    step(8'h5C, 1); check("mov_ex1", obs, pk(0, 0, 4, 0, S_RD, 0));
    step(8'h00, 0); check("mov_ex2", obs, pk(0, 0, 3, 0, S_WR, 0));
    step(8'h00, 0); check("mov_done", obs, pk(1, 0, 0, 0, S_NONE, 0));
    step(8'hC6, 1); check("ldi_fimm", obs, pk(1, 0, 0, 0, S_NONE, 0));
    for (int k = 0; k < 3; k++) begin
      step(8'h77, 0); check("ldi_wait", obs, pk(1, 0, 0, 0, S_NONE, 0));
    end
    step(8'h3A, 1); check("ldi_exec", obs, pk(0, 0, 6, 0, S_LD, 8'h3A));
    step(8'h3A, 1); check("ldi_done", obs, pk(1, 0, 0, 0, S_NONE, 0));
    step(8'hC1, 0); check("ldi_done2", obs, pk(1, 0, 0, 0, S_NONE, 0));
    step(8'hC1, 1); check("ldiff_fimm", obs, pk(1, 0, 0, 0, S_NONE, 0));
    step(8'hFF, 1); check("ldiff_exec", obs, pk(0, 0, 1, 0, S_LD, 8'hFF));
    step(8'h00, 0); check("ldiff_done", obs, pk(1, 0, 0, 0, S_NONE, 0));
    step(8'h07, 1); check("halt", obs, pk(0, 1, 0, 0, S_NONE, 0));
    for (int k = 0; k < 3; k++) begin
      step(8'h95, 1); check("halt_hold", obs, pk(0, 1, 0, 0, S_NONE, 0));
    end
    bus.inst = 8'h00;
    rst = 1'b0;
    #1 check("halt_rst", obs, '0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("halt_rel", obs, pk(1, 0, 0, 0, S_NONE, 0));
    @(negedge clk);
    step(8'h95, 1); check("mid_ex1", obs, pk(0, 0, 5, 0, S_RD, 0));
    bus.instValid = 1'b0;
    #2 rst = 1'b0;
    #1 check("mid_rst", obs, '0);
    @(negedge clk);
    check("mid_hold", obs, '0);
    rst = 1'b1;
    #1 check("mid_rel", obs, pk(1, 0, 0, 0, S_NONE, 0));
    @(negedge clk);
    step(8'h00, 1); check("mid_nop", obs, pk(1, 0, 0, 0, S_NONE, 0));
    step(8'h95, 1); check("mid_again", obs, pk(0, 0, 5, 0, S_RD, 0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
